// File: rtl/psram_target_if.sv
// PSRAM target bus bundle: serial pins from the initiator plus the on-chip
// byte memory port.
//   master : initiator/memory side (drives sclk, cs_n, sio_in, mem_rdata)
//   slave  : psram_target side (drives sio_out/oe and the memory strobes)
interface psram_target_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              spi_sclk;
    logic              spi_cs_n;
    logic [3:0]        sio_in;
    logic [3:0]        sio_out;
    logic [3:0]        sio_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport master (
        output spi_sclk, spi_cs_n, sio_in, mem_rdata,
        input  sio_out, sio_oe, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  spi_sclk, spi_cs_n, sio_in, mem_rdata,
        output sio_out, sio_oe, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/psram_target.sv
// SPI/QPI PSRAM-subset target mapping serial accesses onto a byte memory port.
// All serial pins are oversampled in the clk domain.
// Ports:
//   clk, resetn   system clock, async active-low reset
//   bus (slave)   serial pins + memory port (see psram_target_if)
//   qpi_mode      1 while QPI mode is active
//   busy          synchronised chip-select active
// ADDR_W must be in 8..24; SYNC_STAGES must be at least 2.
module psram_target #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           resetn,
    psram_target_if.slave  bus,
    output logic           qpi_mode,
    output logic           busy
);
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    state_t state, state_d;

    // Synchronisers and edge detection
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
    logic [3:0]             sio_sync [SYNC_STAGES];
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, rise, fall, cs_fall, cs_rise;
    logic [3:0]             sio_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) sio_sync[i] <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            sio_sync[0] <= bus.sio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sio_sync[i] <= sio_sync[i-1];
            sclk_prev   <= sclk_s;
            cs_prev     <= cs_s;
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign sio_s   = sio_sync[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev;
    assign fall    = ~sclk_s & sclk_prev;
    assign cs_fall = ~cs_s & cs_prev;
    assign cs_rise = cs_s & ~cs_prev;

    // Datapath registers
    logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc, step;
    logic [ADDR_W-1:0] in_sh, in_sh_d, in_next;
    logic [ADDR_W-1:0] addr, addr_d;
    logic              is_read, is_read_d, quad_rd, quad_rd_d;
    logic              rst_en, rst_en_d, pend_valid, pend_valid_d, pend_qpi, pend_qpi_d;
    logic              qpi_d;
    logic [7:0]        out_sh, out_sh_d, pf_data, pf_data_d;
    logic [3:0]        out_cnt, out_cnt_d;
    logic              pf_full, pf_full_d, re_q;
    logic [3:0]        sio_out_r, sio_out_d, sio_oe_r, sio_oe_d;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_d;
    logic [7:0]        mem_wdata_r, mem_wdata_d;
    logic              mem_we_r, mem_we_d, mem_re_r, mem_re_d;
    logic [7:0]        in_byte;
    logic              op_wr, op_rd;

    // Serial shift-in: 1 bit per rise in SPI, 1 nibble in QPI; only the low
    // ADDR_W bits are kept, upper address bits fall off the top.
    assign step    = qpi_mode ? CNT_W'(4) : CNT_W'(1);
    assign cnt_inc = cnt + step;
    assign in_next = qpi_mode ? ((in_sh << 4) | ADDR_W'(sio_s))
                              : ((in_sh << 1) | ADDR_W'(sio_s[0]));
    assign in_byte = in_next[7:0];
    assign op_wr   = qpi_mode ? (in_byte == 8'h38) : (in_byte == 8'h02);
    assign op_rd   = qpi_mode ? (in_byte == 8'hEB) : (in_byte == 8'h03);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:   if (cs_fall) state_d = S_CMD;
            S_CMD:    if (rise && cnt_inc == CNT_W'(8))
                          state_d = (op_wr || op_rd) ? S_ADDR : S_IGNORE;
            S_ADDR:   if (rise && cnt_inc == CNT_W'(24))
                          state_d = !is_read ? S_WDATA : (quad_rd ? S_DUMMY : S_RDATA);
            S_DUMMY:  if (rise && cnt == CNT_W'(5)) state_d = S_RDATA;
            S_WDATA, S_RDATA, S_IGNORE: state_d = state;
            default:  state_d = S_IDLE;
        endcase
        if (cs_rise) state_d = S_IDLE;
    end

    // Output / datapath next values
    always_comb begin
        cnt_d        = cnt;
        in_sh_d      = in_sh;
        addr_d       = addr;
        is_read_d    = is_read;
        quad_rd_d    = quad_rd;
        rst_en_d     = rst_en;
        pend_valid_d = pend_valid;
        pend_qpi_d   = pend_qpi;
        qpi_d        = qpi_mode;
        out_sh_d     = out_sh;
        out_cnt_d    = out_cnt;
        pf_data_d    = pf_data;
        pf_full_d    = pf_full;
        sio_out_d    = sio_out_r;
        sio_oe_d     = sio_oe_r;
        mem_addr_d   = mem_addr_r;
        mem_wdata_d  = mem_wdata_r;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;

        // Read data is valid the cycle after mem_re; park it in the prefetch slot
        if (re_q) begin
            pf_data_d = bus.mem_rdata;
            pf_full_d = 1'b1;
        end

        unique case (state)
            S_IDLE: begin
                pf_full_d = 1'b0;
                if (cs_fall) cnt_d = '0;
            end
            S_CMD: if (rise) begin
                in_sh_d = in_next;
                cnt_d   = cnt_inc;
                if (cnt_inc == CNT_W'(8)) begin
                    cnt_d     = '0;
                    rst_en_d  = (in_byte == 8'h66);
                    is_read_d = op_rd;
                    quad_rd_d = qpi_mode;
                    if (in_byte == 8'h99 && rst_en) begin
                        pend_valid_d = 1'b1;
                        pend_qpi_d   = 1'b0;
                    end else if (in_byte == 8'h35 && !qpi_mode) begin
                        pend_valid_d = 1'b1;
                        pend_qpi_d   = 1'b1;
                    end else if (in_byte == 8'hF5 && qpi_mode) begin
                        pend_valid_d = 1'b1;
                        pend_qpi_d   = 1'b0;
                    end
                end
            end
            S_ADDR: if (rise) begin
                in_sh_d = in_next;
                cnt_d   = cnt_inc;
                if (cnt_inc == CNT_W'(24)) begin
                    cnt_d  = '0;
                    addr_d = in_next;
                    if (is_read) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = in_next;
                    end
                end
            end
            S_DUMMY: if (rise) cnt_d = cnt + CNT_W'(1);
            S_WDATA: if (rise) begin
                in_sh_d = in_next;
                cnt_d   = cnt_inc;
                if (cnt_inc == CNT_W'(8)) begin
                    cnt_d       = '0;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = in_byte;
                    mem_addr_d  = addr;
                    addr_d      = addr + ADDR_W'(1);
                end
            end
            S_RDATA: begin
                // Shifter empty: take the fetched byte and prefetch the next one
                if (out_cnt == 4'd0 && (re_q || pf_full)) begin
                    out_sh_d   = re_q ? bus.mem_rdata : pf_data;
                    out_cnt_d  = 4'd8;
                    pf_full_d  = 1'b0;
                    addr_d     = addr + ADDR_W'(1);
                    mem_re_d   = 1'b1;
                    mem_addr_d = addr + ADDR_W'(1);
                end
                if (fall && out_cnt != 4'd0) begin
                    if (qpi_mode) begin
                        sio_out_d = out_sh[7:4];
                        sio_oe_d  = 4'b1111;
                        out_sh_d  = out_sh << 4;
                        out_cnt_d = out_cnt - 4'd4;
                    end else begin
                        sio_out_d = {2'b00, out_sh[7], 1'b0};
                        sio_oe_d  = 4'b0010;
                        out_sh_d  = out_sh << 1;
                        out_cnt_d = out_cnt - 4'd1;
                    end
                end
            end
            S_IGNORE: ;
            default: ;
        endcase

        // End of transaction: release pins, drop buffered data, commit mode change.
        // A byte completing in this same cycle still gets its mem_we.
        if (cs_rise) begin
            cnt_d     = '0;
            sio_oe_d  = 4'b0000;
            sio_out_d = 4'b0000;
            out_cnt_d = 4'd0;
            pf_full_d = 1'b0;
            mem_re_d  = 1'b0;
            if (pend_valid) begin
                qpi_d        = pend_qpi;
                pend_valid_d = 1'b0;
            end
        end
    end

    // Datapath / output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            in_sh       <= '0;
            addr        <= '0;
            is_read     <= 1'b0;
            quad_rd     <= 1'b0;
            rst_en      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_qpi    <= 1'b0;
            qpi_mode    <= 1'b0;
            out_sh      <= '0;
            out_cnt     <= '0;
            pf_data     <= '0;
            pf_full     <= 1'b0;
            re_q        <= 1'b0;
            sio_out_r   <= '0;
            sio_oe_r    <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_we_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            in_sh       <= in_sh_d;
            addr        <= addr_d;
            is_read     <= is_read_d;
            quad_rd     <= quad_rd_d;
            rst_en      <= rst_en_d;
            pend_valid  <= pend_valid_d;
            pend_qpi    <= pend_qpi_d;
            qpi_mode    <= qpi_d;
            out_sh      <= out_sh_d;
            out_cnt     <= out_cnt_d;
            pf_data     <= pf_data_d;
            pf_full     <= pf_full_d;
            re_q        <= mem_re_r;
            sio_out_r   <= sio_out_d;
            sio_oe_r    <= sio_oe_d;
            mem_addr_r  <= mem_addr_d;
            mem_wdata_r <= mem_wdata_d;
            mem_we_r    <= mem_we_d;
            mem_re_r    <= mem_re_d;
            busy        <= ~cs_s;
        end
    end

    assign bus.sio_out   = sio_out_r;
    assign bus.sio_oe    = sio_oe_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_re    = mem_re_r;
endmodule

// File: tb/tb_psram_target.sv
// Directed bench for psram_target: acts as serial initiator and byte memory.
module tb_psram_target;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned HALF   = 6;

    logic clk = 1'b0;
    logic resetn;
    logic qpi_mode, busy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    psram_target_if #(.ADDR_W(ADDR_W)) bus ();

    psram_target #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus.slave),
        .qpi_mode (qpi_mode),
        .busy     (busy)
    );

    // Memory model and strobe monitor
    logic [7:0]        mem [65536];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [7:0]        wr_data_q [$];
    int re_cnt = 0, oe_cnt = 0, both_cnt = 0;

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
        if (bus.mem_re) re_cnt++;
        if (bus.sio_oe != 4'b0000) oe_cnt++;
        if (bus.mem_we && bus.mem_re) both_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cyc(1);
        bus.spi_cs_n = 1'b0;
        cyc(HALF);
    endtask

    task automatic cs_high();
        cyc(HALF);
        bus.spi_cs_n = 1'b1;
        cyc(HALF + 2);
    endtask

    task automatic send(input logic [31:0] val, input int nbits, input bit quad);
        int beats;
        beats = quad ? nbits / 4 : nbits;
        for (int i = 0; i < beats; i++) begin
            if (quad) bus.sio_in = val[nbits-4-4*i +: 4];
            else      bus.sio_in = {3'b000, val[nbits-1-i]};
            cyc(HALF);
            bus.spi_sclk = 1'b1;
            cyc(HALF);
            bus.spi_sclk = 1'b0;
        end
    endtask

    // Host samples sio_out just before each rising edge
    task automatic recv(input int nbits, input bit quad, output logic [31:0] val,
                        output logic [3:0] oe_or, output logic [3:0] oe_and);
        int beats;
        beats  = quad ? nbits / 4 : nbits;
        val    = '0;
        oe_or  = 4'b0000;
        oe_and = 4'b1111;
        for (int i = 0; i < beats; i++) begin
            cyc(HALF);
            val    = quad ? {val[27:0], bus.sio_out} : {val[30:0], bus.sio_out[1]};
            oe_or  = oe_or | bus.sio_oe;
            oe_and = oe_and & bus.sio_oe;
            bus.spi_sclk = 1'b1;
            cyc(HALF);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic wr_txn(input logic [7:0] op, input logic [23:0] a,
                          input logic [31:0] d, input int nbits, input bit quad);
        cs_low();
        send(32'(op), 8, quad);
        send(32'(a), 24, quad);
        send(d, nbits, quad);
        cs_high();
    endtask

    task automatic cmd_txn(input logic [7:0] op, input bit quad);
        cs_low();
        send(32'(op), 8, quad);
        cs_high();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_oe"},    32'(bus.sio_oe),    32'h0);
        chk({tag, "_out"},   32'(bus.sio_out),   32'h0);
        chk({tag, "_we"},    32'(bus.mem_we),    32'h0);
        chk({tag, "_re"},    32'(bus.mem_re),    32'h0);
        chk({tag, "_addr"},  32'(bus.mem_addr),  32'h0);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h0);
        chk({tag, "_qpi"},   32'(qpi_mode),      32'h0);
        chk({tag, "_busy"},  32'(busy),          32'h0);
    endtask

    initial begin
        logic [31:0] rv;
        logic [3:0]  oor, oand;
        int          re_base, oe_base;

        resetn       = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.sio_in   = 4'h0;
        cyc(4);
        check_reset_outputs("rst");
        resetn = 1'b1;
        cyc(4);

        // SPI write 0xA5 0x3C at 0x0010
        cs_low();
        chk("busy_low", 32'(busy), 32'h1);
        send(32'h02, 8, 0);
        send(32'h000010, 24, 0);
        send(32'hA53C, 16, 0);
        cs_high();
        chk("busy_high", 32'(busy), 32'h0);
        chk("spi_wr_n",  32'(wr_addr_q.size()), 32'd2);
        chk("spi_wr_a0", 32'(wr_addr_q[0]), 32'h0010);
        chk("spi_wr_d0", 32'(wr_data_q[0]), 32'hA5);
        chk("spi_wr_a1", 32'(wr_addr_q[1]), 32'h0011);
        chk("spi_wr_d1", 32'(wr_data_q[1]), 32'h3C);
        wr_addr_q.delete();
        wr_data_q.delete();

        // SPI read back
        cs_low();
        send(32'h03, 8, 0);
        send(32'h000010, 24, 0);
        recv(16, 0, rv, oor, oand);
        chk("spi_rd_data", rv, 32'hA53C);
        chk("spi_rd_oe_or", 32'(oor), 32'h2);
        chk("spi_rd_oe_and", 32'(oand), 32'h2);
        cs_high();
        chk("spi_rd_release", 32'(bus.sio_oe), 32'h0);

        // Enter QPI: mode flips only at cs_n rise
        cs_low();
        send(32'h35, 8, 0);
        cyc(HALF);
        chk("qpi_pending", 32'(qpi_mode), 32'h0);
        cs_high();
        chk("qpi_enter", 32'(qpi_mode), 32'h1);

        // QPI write 0xA5 at 0x0000
        wr_txn(8'h38, 24'h000000, 32'hA5, 8, 1);
        chk("qpi_wr_n",  32'(wr_addr_q.size()), 32'd1);
        chk("qpi_wr_a0", 32'(wr_addr_q[0]), 32'h0000);
        chk("qpi_wr_d0", 32'(wr_data_q[0]), 32'hA5);
        wr_addr_q.delete();
        wr_data_q.delete();

        // QPI quad read with 6 dummy edges
        oe_base = oe_cnt;
        cs_low();
        send(32'hEB, 8, 1);
        send(32'h000000, 24, 1);
        send(32'h000000, 24, 1);
        chk("qpi_dummy_oe", 32'(oe_cnt - oe_base), 32'd0);
        recv(8, 1, rv, oor, oand);
        chk("qpi_rd_data", rv, 32'hA5);
        chk("qpi_rd_oe", 32'(oand), 32'hF);
        cs_high();

        // Reset-enable sequencing in QPI
        cmd_txn(8'h99, 1);
        chk("rst_99_alone", 32'(qpi_mode), 32'h1);
        cmd_txn(8'h66, 1);
        cmd_txn(8'h03, 1);
        cmd_txn(8'h99, 1);
        chk("rst_66_03_99", 32'(qpi_mode), 32'h1);
        cmd_txn(8'h66, 1);
        cmd_txn(8'h99, 1);
        chk("rst_66_99", 32'(qpi_mode), 32'h0);

        // Address wrap (upper address byte ignored)
        wr_txn(8'h02, 24'hABFFFF, 32'h112233, 24, 0);
        chk("wrap_n",  32'(wr_addr_q.size()), 32'd3);
        chk("wrap_a0", 32'(wr_addr_q[0]), 32'hFFFF);
        chk("wrap_a1", 32'(wr_addr_q[1]), 32'h0000);
        chk("wrap_a2", 32'(wr_addr_q[2]), 32'h0001);
        chk("wrap_d",  {8'h00, wr_data_q[0], wr_data_q[1], wr_data_q[2]}, 32'h112233);
        wr_addr_q.delete();
        wr_data_q.delete();
        cs_low();
        send(32'h03, 8, 0);
        send(32'h00FFFF, 24, 0);
        recv(24, 0, rv, oor, oand);
        chk("wrap_rd", rv, 32'h112233);
        cs_high();

        // Abort after 12 of 16 data bits
        wr_txn(8'h02, 24'h000100, 32'hC35, 12, 0);
        chk("abort_n",  32'(wr_addr_q.size()), 32'd1);
        chk("abort_a0", 32'(wr_addr_q[0]), 32'h0100);
        chk("abort_d0", 32'(wr_data_q[0]), 32'hC3);
        wr_addr_q.delete();
        wr_data_q.delete();

        // Unknown opcode
        re_base = re_cnt;
        oe_base = oe_cnt;
        cs_low();
        send(32'h9F, 8, 0);
        send(32'hFFFF, 16, 0);
        cs_high();
        chk("unk_we", 32'(wr_addr_q.size()), 32'd0);
        chk("unk_re", 32'(re_cnt - re_base), 32'd0);
        chk("unk_oe", 32'(oe_cnt - oe_base), 32'd0);

        // Reset in the middle of a QPI read
        cmd_txn(8'h35, 0);
        chk("qpi_reenter", 32'(qpi_mode), 32'h1);
        cs_low();
        send(32'hEB, 8, 1);
        send(32'h000000, 24, 1);
        send(32'h000000, 24, 1);
        recv(4, 1, rv, oor, oand);
        chk("midrd_nib", rv, 32'h2);
        chk("midrd_oe", 32'(bus.sio_oe), 32'hF);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.spi_cs_n = 1'b1;
        cyc(4);
        resetn = 1'b1;
        cyc(4);
        cs_low();
        send(32'h03, 8, 0);
        send(32'h000010, 24, 0);
        recv(8, 0, rv, oor, oand);
        chk("post_rst_rd", rv, 32'hA5);
        chk("post_rst_oe", 32'(oand), 32'h2);
        cs_high();

        chk("we_re_overlap", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psram_target.md
Name: psram_target

Overview:
- SPI/QPI target (responder) that speaks the PSRAM command subset our QPI initiator emits.
- Maps serial accesses onto an on-chip byte memory port, so an external host (or a second board acting as initiator) can load programs into, and read back from, the cpu_core memory.
- All serial pins are oversampled in the single system clock domain; no second clock domain.

Parameters:
- ADDR_W, 16, number of low address bits used; upper bits of the 24-bit serial address are ignored.
- SYNC_STAGES, 2, synchroniser depth on sclk, cs_n and sio inputs (minimum 2).

Ports:
- clk  input  1  system clock (12 MHz).
- resetn  input  1  asynchronous active-low reset.
- spi_sclk  input  1  serial clock from initiator.
- spi_cs_n  input  1  chip select, active low.
- sio_in  input  4  sampled SIO pins.
- sio_out  output  4  SIO drive values.
- sio_oe  output  4  per-pin output enable.
- mem_addr  output  ADDR_W  memory byte address.
- mem_wdata  output  8  write data.
- mem_we  output  1  one-cycle write strobe.
- mem_re  output  1  one-cycle read strobe.
- mem_rdata  input  8  read data, valid exactly 1 clk after mem_re.
- qpi_mode  output  1  1 = QPI mode active.
- busy  output  1  high while cs_n is low (synchronised).

Behaviour:
- Reset values: sio_oe=0, sio_out=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, qpi_mode=0, busy=0. State is IDLE and the reset-enable flag is clear.
- Reset mid-transaction aborts immediately; pins are released and no memory strobe is issued.
- Timing constraints:
  - spi_sclk high and low phases are each at least 4 clk.
  - CS setup and hold to SCLK is at least 4 clk.
  - Behaviour outside these constraints is undefined.
- Edge detection: rising and falling edges of spi_sclk are detected on the synchronised signal.
  - Inputs are sampled on rise.
  - Outputs are updated on fall, at most SYNC_STAGES+1 clk after the pin edge.
- Bits per rising edge: 1 on sio_in[0] in SPI mode, 4 (sio_in[3:0], MSB nibble first) in QPI mode. All fields are MSB first.
- States:
  - IDLE: cs_n falling → CMD, clear the bit counter.
  - CMD: collect 8 bits, then decode:
    - 0x66 → set reset-enable flag → IGNORE.
    - 0x99 with flag set → qpi_mode cleared at cs_n rise → IGNORE.
    - 0x35 in SPI → qpi_mode set at cs_n rise → IGNORE.
    - 0xF5 in QPI → qpi_mode cleared at cs_n rise → IGNORE.
    - 0x02 (SPI) or 0x38 (QPI) → ADDR (write).
    - 0x03 (SPI) or 0xEB (QPI) → ADDR (read).
    - Any other opcode → IGNORE.
    - Every command except 0x66 clears the reset-enable flag.
  - ADDR: collect 24 bits; latch the low ADDR_W bits into the address register.
    - Write → WDATA.
    - Read → issue mem_re in the cycle after the last address edge, then go to DUMMY for 0xEB or RDATA for 0x03.
  - DUMMY: 6 rising edges with sio_oe=0, then → RDATA.
  - WDATA: on each completed byte, pulse mem_we for 1 clk with mem_addr=current address and mem_wdata=byte, then increment the address.
  - RDATA: load the output shifter from mem_rdata, then issue the next mem_re with address+1 (prefetch).
    - Shift out on falling edges: SPI drives sio_out[1] only with sio_oe=0010; QPI drives all pins with sio_oe=1111.
    - The first bit or nibble is driven on the first falling edge after entering RDATA.
    - Each time a byte is exhausted, the prefetched byte is loaded and the next prefetch is issued.
  - IGNORE: discard edges until cs_n rises.
- Address increment wraps from 2^ADDR_W−1 to 0.
- cs_n rising (synchronised) in any state:
  - sio_oe=0 on the same cycle; return to IDLE.
  - A partial write byte is discarded (no mem_we).
  - Pending mode changes commit.
- cs_n rising in the same clk as a byte completion: the completed byte is written before the abort.
- mem_we and mem_re are never asserted in the same cycle.

Test Plan:
- Reset: assert resetn=0 mid-QPI-read → all outputs return to reset values within 1 clk, qpi_mode=0, and the next SPI 0x03 works.
- SPI write/read: SPI 0x02, address 0x000010, data 0xA5 0x3C → mem_we at 0x0010=A5 and 0x0011=3C. Then SPI 0x03 at 0x000010 → 0xA5 then 0x3C on sio[1], with sio_oe=0010.
- QPI entry and quad round-trip:
  - SPI 0x35, cs_n high → qpi_mode=1.
  - QPI 0x38 at addr 0x000000 with data 0xA5 → write strobed.
  - QPI 0xEB at 0x000000 → after 6 dummy edges sio_out shows nibbles A then 5, with sio_oe=1111.
- Reset sequence:
  - In QPI, 0x66 then 0x99 → qpi_mode=0.
  - 0x99 without a preceding 0x66 → no change.
  - 0x66, then 0x03 transaction, then 0x99 → no change.
- Wrap-around: with ADDR_W=16, write 3 bytes starting at 0xFFFF → strobes at 0xFFFF, 0x0000, 0x0001. Read across the boundary returns the same bytes.
- Aborts:
  - cs_n raised after 12 of 16 data bits → only the first byte is written.
  - Unknown opcode 0x9F → no strobes and sio_oe stays 0.
